// File: rtl/branch_pc_sequencer.sv
// PC sequencer: sequential fetch, zero-stall jumps, and two-cycle conditional
// branches resolved by the comparator's registered branchYes, with saturating stats.
module branch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IR,
  input  logic             instr_valid,
  input  logic             branchYes,
  output logic [31:0]      pc,
  output logic             stall,
  output logic             redirect,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {FETCH, RESOLVE} state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_bpc;
  logic [31:0]      r_target;
  logic             r_redirect;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic [5:0]  w_op;
  logic        w_is_br;
  logic        w_is_jmp;
  logic [31:0] w_pc4;
  logic [31:0] w_bpc4;
  logic [31:0] w_imm;
  logic [31:0] w_br_tgt;
  logic [31:0] w_jmp_tgt;

  assign w_op      = IR[31:26];
  assign w_is_br   = (w_op >= 6'h08) && (w_op <= 6'h0D);
  assign w_is_jmp  = (w_op == 6'h02);
  assign w_pc4     = r_pc + 32'd4;
  assign w_bpc4    = r_bpc + 32'd4;
  assign w_imm     = {{14{IR[15]}}, IR[15:0], 2'b00};
  assign w_br_tgt  = w_pc4 + w_imm;
  assign w_jmp_tgt = {w_pc4[31:28], IR[25:0], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_bpc        <= RESET_PC;
      r_target     <= RESET_PC;
      r_redirect   <= 1'b0;
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        FETCH: begin
          if (instr_valid) begin
            if (w_is_br) begin
              // pc holds while the comparator registers its decision on this IR
              r_bpc    <= r_pc;
              r_target <= w_br_tgt;
              r_state  <= RESOLVE;
            end else if (w_is_jmp) begin
              r_pc       <= w_jmp_tgt;
              r_redirect <= 1'b1;
            end else begin
              r_pc <= w_pc4;
            end
          end
        end
        RESOLVE: begin
          if (branchYes) begin
            r_pc       <= r_target;
            r_redirect <= 1'b1;
            if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 1'b1;
          end else begin
            r_pc <= w_bpc4;
          end
          if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 1'b1;
          r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign pc         = r_pc;
  assign stall      = (r_state == RESOLVE);
  assign redirect   = r_redirect;
  assign branch_cnt = r_branch_cnt;
  assign taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed bench for branch_pc_sequencer: vector table for the main flows,
// hand-written sequences for counter saturation and reset during resolve.
module tb_branch_pc_sequencer;
  // Narrow counters so saturation is reachable in a short run.
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   IR;
  logic          instr_valid;
  logic          branchYes;
  logic [31:0]   pc;
  logic          stall;
  logic          redirect;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  branch_pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .IR(IR), .instr_valid(instr_valid), .branchYes(branchYes),
    .pc(pc), .stall(stall), .redirect(redirect),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          vld;
    logic [31:0]   ir;
    logic          by;
    logic [31:0]   pc;
    logic          stall;
    logic          red;
    logic [CW-1:0] bcnt;
    logic [CW-1:0] tcnt;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  localparam logic [31:0] ALU = 32'h0000_0020;
  localparam logic [31:0] BR0 = 32'h2000_0000;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] ir, input logic by);
    @(negedge clk);
    rst = r; instr_valid = v; IR = ir; branchYes = by;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] ir, input logic by,
                              input logic [31:0] p, input logic s, input logic rd,
                              input int bc, input int tc);
    vec_t t;
    t.rst = r; t.vld = v; t.ir = ir; t.by = by;
    t.pc = p; t.stall = s; t.red = rd; t.bcnt = CW'(bc); t.tcnt = CW'(tc);
    return t;
  endfunction

  initial begin
    rst = 1'b0; instr_valid = 1'b0; IR = '0; branchYes = 1'b0;

    //              rst vld IR            by  pc            stl red bc tc
    vecs[0]  = mk(0, 1, ALU,          1, 32'h0000_0000, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, ALU,          0, 32'h0000_0000, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, ALU,          0, 32'h0000_0004, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, ALU,          1, 32'h0000_0008, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, ALU,          0, 32'h0000_000C, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, BR0,          1, 32'h0000_000C, 0, 0, 0, 0);
    vecs[6]  = mk(1, 1, 32'h0800_0040, 0, 32'h0000_0100, 0, 1, 0, 0);
    vecs[7]  = mk(1, 1, 32'h2000_0004, 0, 32'h0000_0100, 1, 0, 0, 0);
    vecs[8]  = mk(1, 0, 32'h0800_0080, 1, 32'h0000_0114, 0, 1, 1, 1);
    vecs[9]  = mk(1, 1, 32'h0800_0040, 0, 32'h0000_0100, 0, 1, 1, 1);
    vecs[10] = mk(1, 1, 32'h3400_FFFE, 1, 32'h0000_0100, 1, 0, 1, 1);
    vecs[11] = mk(1, 1, ALU,          0, 32'h0000_0104, 0, 0, 2, 1);
    vecs[12] = mk(1, 1, 32'h0800_0040, 0, 32'h0000_0100, 0, 1, 2, 1);
    vecs[13] = mk(1, 1, 32'h3400_FFFE, 0, 32'h0000_0100, 1, 0, 2, 1);
    vecs[14] = mk(1, 1, ALU,          1, 32'h0000_00FC, 0, 1, 3, 2);
    vecs[15] = mk(1, 1, 32'h0800_0080, 0, 32'h0000_0200, 0, 1, 3, 2);
    vecs[16] = mk(1, 1, 32'h0800_0040, 1, 32'h0000_0100, 0, 1, 3, 2);
    vecs[17] = mk(1, 1, BR0,          0, 32'h0000_0100, 1, 0, 3, 2);
    vecs[18] = mk(1, 1, ALU,          1, 32'h0000_0104, 0, 1, 4, 3);
    vecs[19] = mk(1, 1, 32'h2C00_0003, 1, 32'h0000_0104, 1, 0, 4, 3);
    vecs[20] = mk(1, 1, ALU,          0, 32'h0000_0108, 0, 0, 5, 3);
    vecs[21] = mk(1, 1, 32'h2000_FFBC, 0, 32'h0000_0108, 1, 0, 5, 3);
    vecs[22] = mk(1, 1, ALU,          1, 32'hFFFF_FFFC, 0, 1, 6, 4);
    vecs[23] = mk(1, 1, BR0,          0, 32'hFFFF_FFFC, 1, 0, 6, 4);
    vecs[24] = mk(1, 1, ALU,          1, 32'h0000_0000, 0, 1, 7, 5);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].vld, vecs[i].ir, vecs[i].by);
      chk($sformatf("v%0d pc", i),       pc,                vecs[i].pc);
      chk($sformatf("v%0d stall", i),    {31'b0, stall},    {31'b0, vecs[i].stall});
      chk($sformatf("v%0d redirect", i), {31'b0, redirect}, {31'b0, vecs[i].red});
      chk($sformatf("v%0d branch_cnt", i), 32'(branch_cnt), 32'(vecs[i].bcnt));
      chk($sformatf("v%0d taken_cnt", i),  32'(taken_cnt),  32'(vecs[i].tcnt));
    end

    // Saturation: 300 more taken imm=0 branches from bcnt=7/tcnt=5.
    for (int i = 0; i < 300; i++) begin
      step(1, 1, BR0, 0);
      step(1, 1, ALU, 1);
    end
    chk("sat branch_cnt", 32'(branch_cnt), 32'h0000_00FF);
    chk("sat taken_cnt",  32'(taken_cnt),  32'h0000_00FF);
    chk("sat pc", pc, 32'h0000_04B0);
    step(1, 1, BR0, 0);
    step(1, 1, ALU, 0);
    chk("sat nt branch_cnt", 32'(branch_cnt), 32'h0000_00FF);
    chk("sat nt taken_cnt",  32'(taken_cnt),  32'h0000_00FF);
    chk("sat nt redirect", {31'b0, redirect}, 32'h0);

    // Reset on the resolving edge with branchYes=1 discards the branch.
    step(1, 1, 32'h2000_0010, 0);
    chk("mr stall before", {31'b0, stall}, 32'h1);
    step(0, 1, ALU, 1);
    chk("mr pc",       pc,                32'h0000_0000);
    chk("mr redirect", {31'b0, redirect}, 32'h0);
    chk("mr stall",    {31'b0, stall},    32'h0);
    chk("mr bcnt",     32'(branch_cnt),   32'h0);
    chk("mr tcnt",     32'(taken_cnt),    32'h0);
    step(1, 1, ALU, 1);
    chk("mr fetch pc", pc, 32'h0000_0004);
    chk("mr fetch stall", {31'b0, stall}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_pc_sequencer.md
# branch_pc_sequencer

Program-counter sequencer that consumes the registered `branchYes` decision from the branch comparator and decides the next fetch address. It is the downstream end of the comparator interface. It latches conditional branches (opcodes 0x08–0x0D), holds the PC for one resolve cycle while the comparator registers its decision, then redirects to the branch target or falls through. It also resolves unconditional jumps (opcode 0x02) with no stall, and keeps branch/taken statistics.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `IR`, in, 32: instruction at current `pc`, sharing the same `IR` the comparator samples.
- `instr_valid`, in, 1: `IR` is valid this cycle; when low in FETCH, the PC holds.
- `branchYes`, in, 1: comparator decision, registered by the comparator one edge after it samples `IR`.
- `pc`, out, 32: current fetch address (registered).
- `stall`, out, 1: high while resolving a branch; upstream must not advance.
- `redirect`, out, 1: registered one-cycle pulse after `pc` is loaded with a non-sequential value.
- `branch_cnt`, out, CNT_W: conditional branches resolved (saturating).
- `taken_cnt`, out, CNT_W: conditional branches taken (saturating).

## Operation

- FSM states: FETCH, RESOLVE.
- Opcode is `IR[31:26]`.
- Branch target: `bpc + 4 + (signext(IR[15:0]) << 2)`. Jump target: `{(pc+4)[31:28], IR[25:0], 2'b00}`. All arithmetic is 32-bit modulo 2^32.
- FETCH, `instr_valid`=0: everything holds.
- FETCH, `instr_valid`=1, opcode in 0x08..0x0D:
  - Latch `bpc`←`pc` and the target.
  - `pc` holds; go to RESOLVE.
- FETCH, `instr_valid`=1, opcode 0x02: `pc`←jump target, `redirect`←1, stay in FETCH.
- FETCH, `instr_valid`=1, any other opcode: `pc`←`pc+4`.
- RESOLVE (exactly one cycle; `IR`/`instr_valid` ignored):
  - Sample `branchYes`.
  - If `branchYes`=1: `pc`←latched target, `redirect`←1, `taken_cnt`++.
  - Else: `pc`←`bpc+4`.
  - In both cases `branch_cnt`++; return to FETCH.
- Counters saturate at all-ones and never wrap.
- `redirect` is 0 in every cycle not listed above. A taken branch whose target equals `bpc+4` (imm=0) still pulses `redirect`.
- Unknown and R-type opcodes are treated as sequential; there is no exception path.

## Timing

- Reset (`rst`=0 at an edge):
  - `pc`=RESET_PC, state=FETCH, `stall`=0, `redirect`=0, both counters=0.
  - Any pending branch is discarded, including reset asserted while in RESOLVE.
- `stall` is a combinational decode of state==RESOLVE, so it is high for exactly the one cycle between the latching edge E0 and the resolving edge E1.
- Conditional branch cost: 2 cycles (E0 latch, E1 redirect/fall-through). Jump and sequential cost: 1 cycle.
- `branchYes` is used only at the E1 edge. Its value in FETCH is ignored.
- `redirect` is high in the cycle following the edge that loaded the new `pc`.
- Branch back-to-back with a branch at the target: FETCH at the new `pc` latches it on the edge after E1. There are no lost or merged branches.

## Test plan

- Reset then sequential run: `rst` low 2 cycles → `pc`=0, counters 0. Then 3 valid ALU instructions → `pc`=0x0, 0x4, 0x8, 0xC; `stall`=0 throughout.
- Taken forward branch: `pc`=0x100, `IR` opcode 0x08, imm 0x0004 → `stall`=1 one cycle, `pc` holds 0x100. With `branchYes`=1 at E1 → `pc`=0x114, `redirect` pulse, `branch_cnt`=1, `taken_cnt`=1.
- Not-taken and backward branch:
  - Opcode 0x0D, imm 0xFFFE at 0x100, `branchYes`=0 → `pc`=0x104, no `redirect`.
  - Repeat with `branchYes`=1 → `pc`=0x0FC.
- Jump: `pc`=0x200, `IR`=0x0800_0040 → next `pc`=0x100, `redirect`=1, `stall` never high, counters unchanged.
- Wrap and saturation:
  - `pc`=0xFFFF_FFFC, taken branch imm 0 → `pc`=0x0000_0000.
  - Preset via 2^16+2 resolved taken branches → both counters stick at 0xFFFF.
- Reset mid-resolve: assert `rst`=0 on the E1 edge with `branchYes`=1 → `pc`=RESET_PC, `redirect`=0, counters 0, state FETCH.
